// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter: frame-level arbiter between two Avalon-ST RGB pixel
// sources and the single VGA controller sink. The grant changes only between
// frames, so the sink never receives a torn frame.
// Optional feature macro: VGA_FRAME_ARBITER_FALLBACK_EN. When it is defined, a
// SYNC timeout starts a WIDTH x HEIGHT fallback frame of FILL_COLOR.
module vga_frame_arbiter #(
  parameter int unsigned   DW         = 24,
  parameter int unsigned   WIDTH      = 640,
  parameter int unsigned   HEIGHT     = 480,
  parameter int unsigned   TIMEOUT    = 1024,
  parameter logic [DW-1:0] FILL_COLOR = '0
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          sel,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_sop,
  input  logic          s0_eop,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_sop,
  input  logic          s1_eop,
  output logic          s1_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_sop,
  output logic          m_eop,
  input  logic          m_ready,
  output logic          active_src,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          fallback_active
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               active_src_q, active_src_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               frame_done_q, frame_done_d;

  logic [DW-1:0]      g_data;
  logic               g_valid;
  logic               g_sop;
  logic               g_eop;
  logic               g_ready;

`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
  localparam int unsigned FILL_LAST = (WIDTH * HEIGHT) - 1;

  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]        beat_q, beat_d;
`else
  logic               unused_cfg;
  // Fallback configuration has no effect when the feature is compiled out.
  assign unused_cfg = ^{TIMEOUT, WIDTH, HEIGHT, FILL_COLOR};
`endif

  // Select the granted source's stream.
  always_comb begin
    if (active_src_q) begin
      g_data  = s1_data;
      g_valid = s1_valid;
      g_sop   = s1_sop;
      g_eop   = s1_eop;
    end else begin
      g_data  = s0_data;
      g_valid = s0_valid;
      g_sop   = s0_sop;
      g_eop   = s0_eop;
    end
  end

  // Next-state and streaming outputs; sink sees nothing outside a frame.
  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    m_data       = '0;
    m_valid      = 1'b0;
    m_sop        = 1'b0;
    m_eop        = 1'b0;
    g_ready      = 1'b0;
`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
    to_cnt_d     = '0;
    beat_d       = beat_q;
`endif

    case (state_q)
      SYNC: begin
        // Drop mid-frame beats; hold the sop beat for STREAM to forward.
        g_ready = ~g_sop;
        if (g_valid && g_sop) begin
          state_d = STREAM;
        end
`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
        else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
          if (32'(to_cnt_d) >= TIMEOUT) begin
            state_d  = FILL;
            to_cnt_d = '0;
            beat_d   = '0;
          end
        end
`endif
      end

      STREAM: begin
        m_data  = g_data;
        m_valid = g_valid;
        m_sop   = g_sop;
        m_eop   = g_eop;
        g_ready = m_ready;
        if (g_valid && m_ready && g_eop) begin
          state_d      = SYNC;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          active_src_d = sel;
        end
      end

`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
      FILL: begin
        m_data  = FILL_COLOR;
        m_valid = 1'b1;
        m_sop   = (beat_q == 32'd0);
        m_eop   = (beat_q == FILL_LAST);
        if (m_ready) begin
          if (beat_q == FILL_LAST) begin
            state_d      = SYNC;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            active_src_d = sel;
            beat_d       = '0;
          end else begin
            beat_d = beat_q + 32'd1;
          end
        end
      end
`endif

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= SYNC;
      active_src_q <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
      to_cnt_q     <= '0;
      beat_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
      to_cnt_q     <= to_cnt_d;
      beat_q       <= beat_d;
`endif
    end
  end

  // The non-granted source is always drained so it never backs up.
  assign s0_ready   = active_src_q ? 1'b1 : g_ready;
  assign s1_ready   = active_src_q ? g_ready : 1'b1;
  assign active_src = active_src_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef VGA_FRAME_ARBITER_FALLBACK_EN
  assign fallback_active = (state_q == FILL);
`else
  assign fallback_active = 1'b0;
`endif

endmodule
